// File: rtl/mult_wallace_pipe.sv
// mult_wallace_pipe
//   Pipelined Wallace-tree multiplier with a valid/ready handshake. Each
//   transaction selects unsigned or two's-complement (Baugh-Wooley) operands.
//   Partial-product rows are reduced by levels of 3:2 carry-save adders
//   until two rows remain. The two rows are then summed by a carry-propagate
//   adder in the final stage. The tree levels are spread as evenly as
//   possible across STAGES register stages, and the last of those stages is
//   the output register.
//
// Parameters
//   WIDTH  : operand width, 2..16
//   STAGES : register stages from input to output, 1..4
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready = pipeline advance)
//   in_signed            : 1 = both operands two's complement
//   operand_a, operand_b : multiplicand and multiplier
//   out_valid / out_ready: result handshake
//   result               : 2*WIDTH-bit product
//   result_a, result_b   : registered carry-save rows feeding the final adder
//                          (present only with MULT_WALLACE_PIPE_CSA_OUT_EN)
module mult_wallace_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
`ifdef MULT_WALLACE_PIPE_CSA_OUT_EN
  ,
  output logic [2*WIDTH-1:0]   result_a,
  output logic [2*WIDTH-1:0]   result_b
`endif
);

  localparam int P  = 2 * WIDTH;
  // WIDTH partial-product rows plus one row for the Baugh-Wooley constants.
  localparam int R0 = WIDTH + 1;

  typedef logic [R0-1:0][P-1:0] rows_t;

  // Number of rows entering reduction level lvl.
  function automatic int rows_after(input int lvl);
    int n;
    n = R0;
    for (int k = 0; k < lvl; k++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int c;
    n = R0;
    c = 0;
    for (int k = 0; k < 16; k++) begin
      if (n > 2) begin
        n = 2 * (n / 3) + n % 3;
        c++;
      end
    end
    return c;
  endfunction

  localparam int L = num_levels();

  function automatic rows_t pp_rows(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic             sgn);
    rows_t r;
    logic  bit_v;
    r = '0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        bit_v = a[i] & b[j];
        // Baugh-Wooley: invert products that pair exactly one sign bit.
        if (sgn && ((i == WIDTH-1) != (j == WIDTH-1))) bit_v = ~bit_v;
        r[j][i+j] = bit_v;
      end
    end
    if (sgn) begin
      r[WIDTH][WIDTH] = 1'b1;
      r[WIDTH][P-1]   = 1'b1;
    end
    return r;
  endfunction

  // One Wallace level: each group of three rows becomes a sum row and a
  // shifted carry row; up to two leftover rows pass straight through.
  // Carries out of bit P-1 are dropped (arithmetic is modulo 2^P).
  function automatic rows_t csa_level(input rows_t r, input int n);
    rows_t o;
    int    g;
    o = '0;
    g = n / 3;
    for (int i = 0; i < R0 / 3; i++) begin
      if (i < g) begin
        o[2*i]   = r[3*i] ^ r[3*i+1] ^ r[3*i+2];
        o[2*i+1] = ((r[3*i] & r[3*i+1]) | (r[3*i] & r[3*i+2]) |
                    (r[3*i+1] & r[3*i+2])) << 1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (3*g + k < n) o[2*g+k] = r[3*g+k];
    end
    return o;
  endfunction

  function automatic logic [P-1:0] cpa(input rows_t r);
    return r[0] + r[1];
  endfunction

  logic         adv;
  rows_t        stage_in [STAGES];
  logic         vld_in   [STAGES+1];
  logic [P-1:0] result_p;

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign stage_in[0] = pp_rows(operand_a, operand_b, in_signed);
  assign vld_in[0]   = in_valid & in_ready;
  assign out_valid   = vld_in[STAGES];
  assign result      = result_p;

`ifdef MULT_WALLACE_PIPE_CSA_OUT_EN
  logic [P-1:0] csa_a_p;
  logic [P-1:0] csa_b_p;
  assign result_a = csa_a_p;
  assign result_b = csa_b_p;
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * L / STAGES;
    localparam int HI = (s + 1) * L / STAGES;

    rows_t seg;
    logic  vld_p;

    always_comb begin
      seg = stage_in[s];
      for (int l = LO; l < HI; l++) seg = csa_level(seg, rows_after(l));
    end

    always_ff @(posedge clk) begin
      if (rst)      vld_p <= 1'b0;
      else if (adv) vld_p <= vld_in[s];
    end
    assign vld_in[s+1] = vld_p;

    if (s < STAGES - 1) begin : g_mid
      // ---- stage boundary: carry-save rows registered between tree levels
      rows_t rows_p;
      always_ff @(posedge clk) begin
        if (adv && vld_in[s]) rows_p <= seg;
      end
      assign stage_in[s+1] = rows_p;
    end else begin : g_last
      // ---- output stage: final carry-propagate add registered as result
      always_ff @(posedge clk) begin
        if (rst) begin
          result_p <= '0;
`ifdef MULT_WALLACE_PIPE_CSA_OUT_EN
          csa_a_p  <= '0;
          csa_b_p  <= '0;
`endif
        end else if (adv && vld_in[s]) begin
          result_p <= cpa(seg);
`ifdef MULT_WALLACE_PIPE_CSA_OUT_EN
          csa_a_p  <= seg[0];
          csa_b_p  <= seg[1];
`endif
        end
      end
    end
  end

endmodule
